// File: rtl/nubus_pkg.sv
// Shared definitions for the NuBus SRAM back end: controller states,
// halfword and byte-lane indices, and the per-half byte-lane masks.
package nubus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE,
    RELEASE
  } state_e;

  localparam logic HALF_0 = 1'b0;
  localparam logic HALF_1 = 1'b1;

  localparam int LANE_0 = 0;
  localparam int LANE_1 = 1;
  localparam int LANE_2 = 2;
  localparam int LANE_3 = 3;

  localparam logic [3:0] HALF_LO = 4'b0011;
  localparam logic [3:0] HALF_HI = 4'b1100;

  // Byte-lane write enables {upper, lower} that belong to one SRAM halfword.
  function automatic logic [1:0] lane_enables(input logic [3:0] wr, input logic half);
    if (half == HALF_1) begin
      return wr[LANE_3:LANE_2];
    end
    return wr[LANE_1:LANE_0];
  endfunction

endpackage

// File: rtl/nubus_sram_ctrl.sv
// Turns one 32-bit NuBus slave request into one or two 16-bit asynchronous
// SRAM cycles with a programmable number of extra access clocks.
module nubus_sram_ctrl
  import nubus_pkg::*;
#(
  parameter int SRAM_AW = 19
) (
  input  logic               mem_clk,
  input  logic               mem_reset,
  input  logic               mem_valid,
  input  logic [3:0]         mem_write,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  input  logic               mem_myslot,
  input  logic               mem_myexp,
  input  logic [1:0]         wait_clocks,
  output logic [31:0]        mem_rdata,
  output logic               mem_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_cen,
  output logic               sram_wen,
  output logic               sram_oen,
  output logic               sram_ubn,
  output logic               sram_lbn
);

  state_e             state_q, state_d;
  logic               half_q, half_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [SRAM_AW-2:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wr_q, wr_d;
  logic [1:0]         w_q, w_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               ready_q;

  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_o_q, dq_o_d;
  logic               dq_oe_q, dq_oe_d;
  logic               cen_q, cen_d;
  logic               wen_q, wen_d;
  logic               oen_q, oen_d;
  logic               ubn_q, ubn_d;
  logic               lbn_q, lbn_d;

  logic               out_busy;
  logic               out_read;
  logic [1:0]         out_lanes;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:SRAM_AW+1], mem_addr[1:0]};

  // Sequencing of halves; a write skips any half with no byte lanes enabled.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    w_d     = w_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (mem_valid && (mem_myslot || mem_myexp)) begin
          state_d = SETUP;
          addr_d  = mem_addr[SRAM_AW:2];
          wdata_d = mem_wdata;
          wr_d    = mem_write;
          w_d     = wait_clocks;
          half_d  = ((mem_write != 4'b0) && ((mem_write & HALF_LO) == 4'b0)) ? HALF_1 : HALF_0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = w_q;
      end
      ACCESS: begin
        if (cnt_q == 2'd0) begin
          state_d = HOLD;
          if (wr_q == 4'b0) begin
            if (half_q == HALF_1) begin
              rdata_d[31:16] = sram_dq_i;
            end else begin
              rdata_d[15:0] = sram_dq_i;
            end
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      HOLD: begin
        if ((half_q == HALF_0) && ((wr_q == 4'b0) || ((wr_q & HALF_HI) != 4'b0))) begin
          state_d = SETUP;
          half_d  = HALF_1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!mem_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pins are decoded from the next state so they leave the flops glitch-free.
  always_comb begin
    out_busy    = (state_d == SETUP) || (state_d == ACCESS) || (state_d == HOLD);
    out_read    = (wr_d == 4'b0);
    out_lanes   = lane_enables(wr_d, half_d);
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = 1'b0;
    cen_d       = 1'b1;
    wen_d       = 1'b1;
    oen_d       = 1'b1;
    ubn_d       = 1'b1;
    lbn_d       = 1'b1;
    if (out_busy) begin
      cen_d       = 1'b0;
      sram_addr_d = {addr_d, half_d};
      if (out_read) begin
        ubn_d = 1'b0;
        lbn_d = 1'b0;
      end else begin
        ubn_d   = ~out_lanes[1];
        lbn_d   = ~out_lanes[0];
        dq_oe_d = 1'b1;
        dq_o_d  = (half_d == HALF_1) ? wdata_d[31:16] : wdata_d[15:0];
      end
      if (state_d == ACCESS) begin
        wen_d = out_read;
        oen_d = !out_read;
      end
    end
  end

  // Control and request registers.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      state_q <= IDLE;
      half_q  <= HALF_0;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      wr_q    <= 4'h0;
      w_q     <= 2'd0;
      rdata_q <= 32'h0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      w_q     <= w_d;
      rdata_q <= rdata_d;
      ready_q <= (state_q == DONE);
    end
  end

  // SRAM pin registers; reset parks the chip deselected with the bus released.
  always_ff @(posedge mem_clk or posedge mem_reset) begin
    if (mem_reset) begin
      sram_addr_q <= '0;
      dq_o_q      <= 16'h0;
      dq_oe_q     <= 1'b0;
      cen_q       <= 1'b1;
      wen_q       <= 1'b1;
      oen_q       <= 1'b1;
      ubn_q       <= 1'b1;
      lbn_q       <= 1'b1;
    end else begin
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      cen_q       <= cen_d;
      wen_q       <= wen_d;
      oen_q       <= oen_d;
      ubn_q       <= ubn_d;
      lbn_q       <= lbn_d;
    end
  end

  assign mem_rdata  = rdata_q;
  assign mem_ready  = ready_q;
  assign sram_addr  = sram_addr_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_cen   = cen_q;
  assign sram_wen   = wen_q;
  assign sram_oen   = oen_q;
  assign sram_ubn   = ubn_q;
  assign sram_lbn   = lbn_q;

endmodule

// File: doc/nubus_sram_ctrl.md
Name: nubus_sram_ctrl

Overview:
Downstream stage of the NuBus slave: consumes the slave's mem_* request interface and drives an external 16-bit asynchronous SRAM. Each 32-bit NuBus access is split into up to two halfword SRAM cycles with programmable wait states. When the access completes, the block returns mem_ready and, for reads, mem_rdata. It is the synthesizable replacement for the behavioural memory model used in slave simulation.

Parameters:
SRAM_AW, 19, SRAM halfword address width; SRAM halfword address = {mem_addr[SRAM_AW:2], half}.

Ports:
mem_clk  in  1  clock; the same clock the slave mem_* interface uses
mem_reset  in  1  reset, asynchronous, active-high
mem_valid  in  1  request from slave; held high until mem_ready
mem_write  in  4  byte-lane write enables; 0 = read; bit0 = bits 7:0
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_myslot  in  1  request targets this slot space
mem_myexp  in  1  request targets this card's expansion space
wait_clocks  in  2  extra ACCESS cycles (W); sampled at accept
mem_rdata  out  32  read data; holds value until the next read completes
mem_ready  out  1  one-cycle completion pulse
sram_addr  out  SRAM_AW  halfword address
sram_dq_o  out  16  write data
sram_dq_i  in  16  read data
sram_dq_oe  out  1  data-bus output enable
sram_cen  out  1  chip enable, active-low
sram_wen  out  1  write enable, active-low
sram_oen  out  1  output enable, active-low
sram_ubn  out  1  upper byte enable, active-low
sram_lbn  out  1  lower byte enable, active-low

Behaviour:
- Reset (async, any state): state=IDLE; mem_ready=0; mem_rdata=0; sram_cen, sram_wen, sram_oen, sram_ubn, sram_lbn = 1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0.
- Accept: in IDLE, on a clock edge with mem_valid & (mem_myslot | mem_myexp), latch addr, wdata, write, W.
- Deselect: mem_valid high with both select inputs low is ignored; mem_ready never asserts.
- Half selection:
  - Read: always half 0 (bits 15:0) then half 1 (bits 31:16).
  - Write: half 0 only if write[1:0]!=0; half 1 only if write[3:2]!=0.
- Byte enables:
  - Write: half 0 uses lbn=~write[0], ubn=~write[1]; half 1 uses lbn=~write[2], ubn=~write[3].
  - Read: lbn=0 and ubn=0.
- States:
  - IDLE: on accept go to SETUP with the first selected half.
  - SETUP (1 cycle): drive sram_addr, cen=0, byte enables. For writes, drive dq_o and set dq_oe=1.
  - ACCESS (W+1 cycles, down-counter): write keeps wen=0; read keeps oen=0. For a read, sram_dq_i is captured into the matching mem_rdata half on the edge ending the last ACCESS cycle.
  - HOLD (1 cycle): wen=1 and oen=1. cen, address and dq stay driven to meet hold time. Then go to SETUP for the next selected half, else DONE.
  - DONE (1 cycle): mem_ready=1; cen=1, all byte enables=1, dq_oe=0. Then go to RELEASE.
  - RELEASE: wait until mem_valid=0, then go to IDLE. This prevents re-accepting the same request.
- Latency: one half costs W+3 cycles. mem_ready asserts N×(W+3)+1 cycles after the accept edge, where N is the number of selected halves (1 or 2). Example: W=1 word access gives 9.
- Read data: mem_rdata updates only on reads, one half at a time. The combined value is stable when mem_ready asserts.
- Protocol violation: if mem_valid drops mid-access, the access completes anyway; mem_ready still pulses.
- wait_clocks changes mid-access have no effect until the next accept.

Decomposition:
- Shared package nubus_pkg:
  - state enum (IDLE, SETUP, ACCESS, HOLD, DONE, RELEASE)
  - halfword/byte-lane index constants
  - HALF_LO/HALF_HI masks
- No sub-module. The wait down-counter and half-select logic are inline; the RTL is about 200 lines.

Test Plan:
1. Reset held with random inputs -> cen, wen, oen, ubn, lbn all 1; dq_oe=0; mem_ready=0; mem_rdata=0. Assert reset mid-ACCESS of a write -> wen=1 immediately, no mem_ready; the next request completes normally.
2. W=1, write mem_write=4'hF, addr 0xF0000000, data 0x87654321, myslot=1 -> SRAM writes 0x4321 @0 then 0x8765 @1 with ubn=lbn=0; mem_ready exactly 9 cycles after accept, single pulse.
3. W=1, read addr 0xF0000000 (SRAM model holds 0x4321/0x8765) -> mem_rdata=0x87654321 when mem_ready asserts at cycle 9; mem_rdata unchanged after a subsequent write.
4. W=1, byte-3 write mem_write=4'b1000, data 0x87654321, addr 0xF0000018 -> one SRAM cycle @ halfword 13 with ubn=0, lbn=1, dq_o=0x8765; mem_ready at cycle 5. Half-0 write 4'b0011 -> only @12 with data 0x4321, ready at cycle 5.
5. W=3 read -> each ACCESS lasts 4 cycles, ready at cycle 13. Deselected request (myslot=0, myexp=0, valid held 20 cycles) -> no SRAM activity, no ready.
6. mem_valid held high 5 cycles after mem_ready -> no second access; a new request after valid low/high is accepted and served.
